mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports (CPU, DMA) and the shared memory port.
// Latency: none, wiring only.
// Backpressure: requesters hold req until gnt; stall tells the CPU to freeze.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter view.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  mem_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_addr, mem_wdata, mem_read, mem_write
   );

   // Requester + memory view.
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output mem_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_addr, mem_wdata, mem_read, mem_write
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU/DMA) bounded-burst round-robin arbiter for one unified memory; optional perf counters via ARB_PERF_EN.
// Latency: gnt combinational in IDLE; write occupies 2 cycles, read MEM_LAT+2 with rvalid in the last one.
// Backpressure: at most one access in flight; losers keep req high, cpu_stall freezes the CPU FSM.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 1,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_port_arbiter_if.slave    bus
`ifdef ARB_PERF_EN
   ,
   output logic [31:0]          perf_conflict_cnt,
   output logic [31:0]          perf_cpu_stall_cnt
`endif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
   // WAIT lasts MEM_LAT-1 cycles; the counter runs down to zero.
   localparam logic [1:0] WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

   logic [1:0]        state;
   logic              last_owner;
   logic              owner;
   logic [3:0]        burst_cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_we;
   logic [1:0]        wait_cnt;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;

   logic              sel_vld;
   logic              sel_owner;
   logic              mem_busy;
   logic              capture;
   logic              cpu_stall_c;

   // Pick at most one requester in IDLE; the incumbent keeps the port until its burst is used up.
   always_comb begin
      sel_vld   = 1'b0;
      sel_owner = OWN_CPU;
      if (reset && state == S_IDLE) begin
         if (bus.cpu_req && bus.dma_req) begin
            sel_vld   = 1'b1;
            sel_owner = (burst_cnt == BURST_MAX) ? ~last_owner : last_owner;
         end else if (bus.cpu_req) begin
            sel_vld   = 1'b1;
            sel_owner = OWN_CPU;
         end else if (bus.dma_req) begin
            sel_vld   = 1'b1;
            sel_owner = OWN_DMA;
         end
      end
   end

   assign mem_busy = (state == S_ACCESS) || (state == S_WAIT);

   // Read data is taken on the last edge the read strobe is held.
   assign capture = ((state == S_ACCESS) && !lat_we && (MEM_LAT == 1)) ||
                    ((state == S_WAIT) && (wait_cnt == 2'd0));

   assign cpu_stall_c = (bus.cpu_req && !bus.cpu_gnt) ||
                        ((owner == OWN_CPU) && !lat_we && mem_busy);

   assign bus.cpu_gnt    = sel_vld && (sel_owner == OWN_CPU);
   assign bus.dma_gnt    = sel_vld && (sel_owner == OWN_DMA);
   assign bus.cpu_rvalid = (state == S_RESP) && (owner == OWN_CPU);
   assign bus.dma_rvalid = (state == S_RESP) && (owner == OWN_DMA);
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.dma_rdata  = dma_rdata_q;
   assign bus.cpu_stall  = cpu_stall_c;
   assign bus.mem_addr   = mem_busy ? lat_addr : '0;
   assign bus.mem_read   = mem_busy && !lat_we;
   assign bus.mem_write  = (state == S_ACCESS) && lat_we;
   assign bus.mem_wdata  = ((state == S_ACCESS) && lat_we) ? lat_wdata : '0;

   // Access sequencer: latch the winner, strobe memory, count read latency, pulse the response.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         last_owner <= OWN_CPU;
         owner      <= OWN_CPU;
         burst_cnt  <= 4'd0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_we     <= 1'b0;
         wait_cnt   <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_vld) begin
                  owner      <= sel_owner;
                  last_owner <= sel_owner;
                  lat_addr   <= (sel_owner == OWN_DMA) ? bus.dma_addr  : bus.cpu_addr;
                  lat_wdata  <= (sel_owner == OWN_DMA) ? bus.dma_wdata : bus.cpu_wdata;
                  lat_we     <= (sel_owner == OWN_DMA) ? bus.dma_we    : bus.cpu_we;
                  if (sel_owner != last_owner)
                     burst_cnt <= 4'd1;
                  else if (burst_cnt < BURST_MAX)
                     burst_cnt <= burst_cnt + 4'd1;
                  state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (lat_we) begin
                  state <= S_IDLE;
               end else if (MEM_LAT == 1) begin
                  state <= S_RESP;
               end else begin
                  wait_cnt <= WAIT_INIT;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 2'd0)
                  state <= S_RESP;
               else
                  wait_cnt <= wait_cnt - 2'd1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Per-port read data registers; each holds until that port's next read completes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else if (capture) begin
         if (owner == OWN_DMA)
            dma_rdata_q <= bus.mem_rdata;
         else
            cpu_rdata_q <= bus.mem_rdata;
      end
   end

`ifdef ARB_PERF_EN
   // Contention and CPU-stall cycle counters, free-running modulo 2^32.
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_conflict_cnt  <= 32'd0;
         perf_cpu_stall_cnt <= 32'd0;
      end else begin
         if (state == S_IDLE && bus.cpu_req && bus.dma_req)
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         if (cpu_stall_c)
            perf_cpu_stall_cnt <= perf_cpu_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a (MEM_LAT=1, MAX_BURST=4) and dut_b (MEM_LAT=3, MAX_BURST=1).
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: requesters drop req in the cycle after their gnt.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ba ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bb ();

`ifdef ARB_PERF_EN
   logic [31:0] conf_a, stall_a, conf_b, stall_b;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_BURST(4)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ba)
`ifdef ARB_PERF_EN
      , .perf_conflict_cnt (conf_a), .perf_cpu_stall_cnt (stall_a)
`endif
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_BURST(1)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bb)
`ifdef ARB_PERF_EN
      , .perf_conflict_cnt (conf_b), .perf_cpu_stall_cnt (stall_b)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      ba.cpu_req = 1'b0; ba.cpu_we = 1'b0; ba.cpu_addr = '0; ba.cpu_wdata = '0;
      ba.dma_req = 1'b0; ba.dma_we = 1'b0; ba.dma_addr = '0; ba.dma_wdata = '0;
      ba.mem_rdata = '0;
      bb.cpu_req = 1'b0; bb.cpu_we = 1'b0; bb.cpu_addr = '0; bb.cpu_wdata = '0;
      bb.dma_req = 1'b0; bb.dma_we = 1'b0; bb.dma_addr = '0; bb.dma_wdata = '0;
      bb.mem_rdata = '0;
      tick;
      tick;

      // Reset state
      chk1("rst_cpu_gnt", ba.cpu_gnt, 1'b0);
      chk1("rst_mem_read", ba.mem_read, 1'b0);
      chk1("rst_mem_write", ba.mem_write, 1'b0);
      chk1("rst_cpu_stall", ba.cpu_stall, 1'b0);
      chk1("rst_rvalid", ba.cpu_rvalid | ba.dma_rvalid, 1'b0);
      chk("rst_mem_addr", ba.mem_addr, 32'h0);
      chk("rst_cpu_rdata", ba.cpu_rdata, 32'h0);
      chk("rst_b_mem_read", {31'd0, bb.mem_read}, 32'h0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick;

      // 1. CPU read alone, MEM_LAT=1
      ba.cpu_req = 1'b1; ba.cpu_we = 1'b0; ba.cpu_addr = 32'h40; ba.mem_rdata = 32'h1234;
      settle;
      chk1("t1_cpu_gnt", ba.cpu_gnt, 1'b1);
      chk1("t1_dma_gnt", ba.dma_gnt, 1'b0);
      chk1("t1_stall_T", ba.cpu_stall, 1'b0);
      tick;
      ba.cpu_req = 1'b0;
      settle;
      chk1("t1_mem_read", ba.mem_read, 1'b1);
      chk1("t1_mem_write", ba.mem_write, 1'b0);
      chk("t1_mem_addr", ba.mem_addr, 32'h40);
      chk1("t1_stall_acc", ba.cpu_stall, 1'b1);
      chk1("t1_rvalid_early", ba.cpu_rvalid, 1'b0);
      tick;
      settle;
      chk1("t1_cpu_rvalid", ba.cpu_rvalid, 1'b1);
      chk("t1_cpu_rdata", ba.cpu_rdata, 32'h1234);
      chk1("t1_dma_rvalid", ba.dma_rvalid, 1'b0);
      chk1("t1_stall_resp", ba.cpu_stall, 1'b0);
      chk1("t1_read_off", ba.mem_read, 1'b0);
      chk("t1_addr_off", ba.mem_addr, 32'h0);
      ba.cpu_req = 1'b1; ba.cpu_we = 1'b1; ba.cpu_addr = 32'h44; ba.cpu_wdata = 32'h11;
      settle;
      chk1("t1_no_gnt_resp", ba.cpu_gnt, 1'b0);
      chk1("t1_stall_wait_gnt", ba.cpu_stall, 1'b1);
      tick;
      settle;
      chk1("t1_gnt_T3", ba.cpu_gnt, 1'b1);
      tick;
      ba.cpu_req = 1'b0;
      settle;
      chk1("t1_wr_strobe", ba.mem_write, 1'b1);
      chk("t1_wr_data", ba.mem_wdata, 32'h11);
      chk1("t1_wr_no_stall", ba.cpu_stall, 1'b0);
      chk("t1_rdata_held", ba.cpu_rdata, 32'h1234);
      tick;

      // 2. DMA write alone
      ba.dma_req = 1'b1; ba.dma_we = 1'b1; ba.dma_addr = 32'h100; ba.dma_wdata = 32'hDEAD_BEEF;
      settle;
      chk1("t2_dma_gnt", ba.dma_gnt, 1'b1);
      chk1("t2_cpu_gnt", ba.cpu_gnt, 1'b0);
      tick;
      ba.dma_req = 1'b0;
      settle;
      chk1("t2_mem_write", ba.mem_write, 1'b1);
      chk1("t2_mem_read", ba.mem_read, 1'b0);
      chk("t2_mem_addr", ba.mem_addr, 32'h100);
      chk("t2_mem_wdata", ba.mem_wdata, 32'hDEAD_BEEF);
      tick;
      settle;
      chk1("t2_no_rvalid", ba.cpu_rvalid | ba.dma_rvalid, 1'b0);
      chk1("t2_write_off", ba.mem_write, 1'b0);
      chk("t2_wdata_off", ba.mem_wdata, 32'h0);
      ba.dma_req = 1'b1; ba.dma_addr = 32'h104;
      settle;
      chk1("t2_idle_gnt", ba.dma_gnt, 1'b1);
      tick;
      ba.dma_req = 1'b0;
      tick;

      // 3. Continuous contention after reset: burst 4 on dut_a, alternation on dut_b
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick;
      rst_a = 1'b1;
      rst_b = 1'b1;
      ba.cpu_req = 1'b1; ba.cpu_we = 1'b1; ba.cpu_addr = 32'h10; ba.cpu_wdata = 32'h1;
      ba.dma_req = 1'b1; ba.dma_we = 1'b1; ba.dma_addr = 32'h20; ba.dma_wdata = 32'h2;
      bb.cpu_req = 1'b1; bb.cpu_we = 1'b1; bb.cpu_addr = 32'h10; bb.cpu_wdata = 32'h1;
      bb.dma_req = 1'b1; bb.dma_we = 1'b1; bb.dma_addr = 32'h20; bb.dma_wdata = 32'h2;
      for (int i = 0; i < 9; i++) begin
         settle;
         chk($sformatf("t3_burst_order_%0d", i), {30'd0, ba.cpu_gnt, ba.dma_gnt},
             (i < 4) ? 32'd2 : ((i < 8) ? 32'd1 : 32'd2));
         chk($sformatf("t3_alt_order_%0d", i), {30'd0, bb.cpu_gnt, bb.dma_gnt},
             (i % 2 == 0) ? 32'd2 : 32'd1);
         tick;
         chk($sformatf("t3_no_b2b_%0d", i), {30'd0, ba.cpu_gnt, ba.dma_gnt}, 32'd0);
         tick;
      end
      ba.cpu_req = 1'b0; ba.dma_req = 1'b0;
      bb.cpu_req = 1'b0; bb.dma_req = 1'b0;

      // 4. MEM_LAT=3 DMA read while CPU requests; last owner CPU at burst limit -> DMA wins
      bb.dma_req = 1'b1; bb.dma_we = 1'b0; bb.dma_addr = 32'h200;
      bb.cpu_req = 1'b1; bb.cpu_we = 1'b1; bb.cpu_addr = 32'h300; bb.cpu_wdata = 32'h5;
      settle;
      chk1("t4_dma_gnt", bb.dma_gnt, 1'b1);
      chk1("t4_cpu_gnt_T", bb.cpu_gnt, 1'b0);
      chk1("t4_stall_T", bb.cpu_stall, 1'b1);
      tick;
      bb.dma_req = 1'b0;
      bb.mem_rdata = 32'hEEEE_0001;
      settle;
      chk1("t4_read_1", bb.mem_read, 1'b1);
      chk("t4_addr_1", bb.mem_addr, 32'h200);
      chk1("t4_stall_1", bb.cpu_stall, 1'b1);
      tick;
      bb.mem_rdata = 32'hEEEE_0002;
      settle;
      chk1("t4_read_2", bb.mem_read, 1'b1);
      chk1("t4_stall_2", bb.cpu_stall, 1'b1);
      chk1("t4_rvalid_2", bb.dma_rvalid, 1'b0);
      tick;
      bb.mem_rdata = 32'hCAFE_0003;
      settle;
      chk1("t4_read_3", bb.mem_read, 1'b1);
      chk("t4_addr_3", bb.mem_addr, 32'h200);
      chk1("t4_stall_3", bb.cpu_stall, 1'b1);
      chk1("t4_rvalid_3", bb.dma_rvalid, 1'b0);
      tick;
      bb.mem_rdata = 32'hEEEE_0004;
      settle;
      chk1("t4_dma_rvalid", bb.dma_rvalid, 1'b1);
      chk("t4_dma_rdata", bb.dma_rdata, 32'hCAFE_0003);
      chk1("t4_cpu_rvalid", bb.cpu_rvalid, 1'b0);
      chk1("t4_read_off", bb.mem_read, 1'b0);
      chk1("t4_no_gnt_resp", bb.cpu_gnt, 1'b0);
      chk1("t4_stall_resp", bb.cpu_stall, 1'b1);
      tick;
      settle;
      chk1("t4_cpu_gnt", bb.cpu_gnt, 1'b1);
      chk1("t4_stall_clear", bb.cpu_stall, 1'b0);
      chk1("t4_rvalid_off", bb.dma_rvalid, 1'b0);
      chk("t4_rdata_held", bb.dma_rdata, 32'hCAFE_0003);
      tick;
      bb.cpu_req = 1'b0;
      settle;
      chk1("t4_cpu_write", bb.mem_write, 1'b1);
      chk("t4_cpu_addr", bb.mem_addr, 32'h300);
      tick;

      // 5. Reset during WAIT of a CPU read abandons it
      bb.cpu_req = 1'b1; bb.cpu_we = 1'b0; bb.cpu_addr = 32'h400;
      settle;
      chk1("t5_gnt", bb.cpu_gnt, 1'b1);
      tick;
      bb.cpu_req = 1'b0;
      tick;
      settle;
      chk1("t5_wait_read", bb.mem_read, 1'b1);
      chk1("t5_wait_stall", bb.cpu_stall, 1'b1);
      rst_b = 1'b0;
      tick;
      chk1("t5_rst_read", bb.mem_read, 1'b0);
      chk1("t5_rst_write", bb.mem_write, 1'b0);
      chk("t5_rst_addr", bb.mem_addr, 32'h0);
      chk1("t5_rst_stall", bb.cpu_stall, 1'b0);
      chk1("t5_rst_rvalid", bb.cpu_rvalid | bb.dma_rvalid, 1'b0);
      chk("t5_rst_cpu_rdata", bb.cpu_rdata, 32'h0);
      chk("t5_rst_dma_rdata", bb.dma_rdata, 32'h0);
      rst_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk1($sformatf("t5_no_rvalid_%0d", i), bb.cpu_rvalid, 1'b0);
      end
      bb.cpu_req = 1'b1; bb.cpu_we = 1'b1; bb.cpu_addr = 32'h500;
      settle;
      chk1("t5_regrant", bb.cpu_gnt, 1'b1);
      tick;
      bb.cpu_req = 1'b0;
      tick;

`ifdef ARB_PERF_EN
      // 6. Ten cycles of contention: 5 IDLE conflict cycles, 6 CPU stall cycles
      rst_a = 1'b0;
      tick;
      rst_a = 1'b1;
      ba.cpu_req = 1'b1; ba.cpu_we = 1'b1;
      ba.dma_req = 1'b1; ba.dma_we = 1'b1;
      for (int i = 0; i < 10; i++) tick;
      ba.cpu_req = 1'b0; ba.dma_req = 1'b0;
      settle;
      chk("t6_conflict_cnt", conf_a, 32'd5);
      chk("t6_stall_cnt", stall_a, 32'd6);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
